// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: queues producer writes and issues one
// tx_wr load strobe per byte, pacing itself on the transmitter's tx_empty flag.
module uart_tx_fifo #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned BUSY_TIMEOUT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     tx_empty,
  output logic                     tx_wr,
  output logic [7:0]               tx_byte
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [7:0]      mem_q [DEPTH];
  logic            wr_acc;
  logic            pop;

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    tx_byte_d  = tx_byte_q;
    to_cnt_d   = to_cnt_q;
    pop        = 1'b0;

    // Acceptance uses only registered full/empty, so a fresh write never
    // bypasses storage and a full FIFO drops the write even if a pop happens.
    wr_acc     = wr_en && !full_q;
    overflow_d = wr_en && full_q;
    wr_ptr_d   = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;

    unique case (state_q)
      IDLE: begin
        if (!empty_q && tx_empty) begin
          pop       = 1'b1;
          state_d   = LOAD;
          tx_byte_d = mem_q[rd_ptr_q];
          rd_ptr_d  = rd_ptr_q + 1'b1;
        end
      end
      LOAD: begin
        state_d  = WAIT_BUSY;
        to_cnt_d = '0;
      end
      WAIT_BUSY: begin
        if (!tx_empty) begin
          state_d  = WAIT_DONE;
          to_cnt_d = '0;
        end else if (to_cnt_q == TW'(BUSY_TIMEOUT - 1)) begin
          state_d  = IDLE;
          to_cnt_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (tx_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    count_d = count_q + CW'(wr_acc) - CW'(pop);
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      tx_byte_q  <= '0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      tx_byte_q  <= tx_byte_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= din;
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign tx_byte  = tx_byte_q;
  assign tx_wr    = (state_q == LOAD);

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 16: FIFO entries; the value SHALL be a power of two and at least 2.
REQ-002 Parameter BUSY_TIMEOUT, default 4: cycles to wait for the transmitter to report busy after a load.
REQ-003 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-low (0 = reset).
REQ-005 wr_en  input  1  write strobe from the producer.
REQ-006 din  input  8  byte to enqueue.
REQ-007 full  output  1  FIFO holds DEPTH entries.
REQ-008 empty  output  1  FIFO holds 0 entries.
REQ-009 count  output  log2(DEPTH)+1  current number of entries.
REQ-010 overflow  output  1  one-cycle pulse when a write is dropped.
REQ-011 tx_empty  input  1  transmitter idle flag; 1 = idle.
REQ-012 tx_wr  output  1  one-cycle load strobe to the transmitter.
REQ-013 tx_byte  output  8  byte presented to the transmitter; registered.

Function
REQ-014 A write SHALL be accepted at a rising edge when wr_en=1 and full=0 (registered value); din stored at the write pointer; pointer increments modulo DEPTH.
REQ-015 With wr_en=1 and full=1, the write SHALL be dropped and overflow=1 for exactly the following cycle, even if a pop occurs in the same cycle.
REQ-016 count, full and empty SHALL be registered and consistent every cycle: full=(count==DEPTH), empty=(count==0); simultaneous accepted write and pop SHALL leave count unchanged.
REQ-017 The FSM SHALL have four states: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
REQ-018 IDLE->LOAD when empty=0 and tx_empty=1; on this edge tx_byte SHALL take the head entry and the read pointer SHALL increment modulo DEPTH.
REQ-019 LOAD SHALL last exactly one cycle, with tx_wr=1; tx_wr SHALL be 0 in every other state; LOAD->WAIT_BUSY unconditionally.
REQ-020 WAIT_BUSY->WAIT_DONE when tx_empty=0; WAIT_BUSY->IDLE when tx_empty remains 1 for BUSY_TIMEOUT consecutive cycles; timeout counter cleared on entry.
REQ-021 WAIT_DONE->IDLE when tx_empty=1.
REQ-022 tx_byte SHALL hold its value from the LOAD edge until the next IDLE->LOAD edge.
REQ-023 Latency: write accepted at edge k into an empty FIFO with FSM in IDLE and tx_empty=1 -> LOAD entered at edge k+1; tx_wr high between edges k+1 and k+2.
REQ-024 Each accepted byte SHALL produce exactly one tx_wr pulse; bytes SHALL be issued in write order with no loss or duplication.
REQ-025 A write into an empty FIFO SHALL NOT bypass storage; empty is evaluated from registered state only.
REQ-026 wr_en and tx_empty SHALL be treated as synchronous to clk; no internal synchronizer.

Reset
REQ-027 While rst=0: pointers=0, count=0, empty=1, full=0, overflow=0, tx_wr=0, tx_byte=8'h00, FSM=IDLE, timeout counter=0; takes effect without a clock edge.
REQ-028 Reset mid-operation SHALL discard all queued bytes and abort any pending load; the downstream transmitter is not reset by this block.
REQ-029 First valid write SHALL be the first rising edge with rst=1.

Verification
REQ-030 Single byte: write 8'hA5 into an idle FIFO with tx_empty=1 -> one tx_wr pulse two edges later, tx_byte=8'hA5, count returns to 0.
REQ-031 Burst: write 8'h01..8'h05 on consecutive cycles while the modelled transmitter holds tx_empty=0 for 20 cycles per byte -> five tx_wr pulses, bytes in order, each pulse only after tx_empty returns to 1.
REQ-032 Overflow: DEPTH=16, tx_empty=0, 17 writes -> full=1, count=16, one overflow pulse on the 17th write; 17th byte never transmitted.
REQ-033 Wrap-around: 40 bytes streamed through DEPTH=16 with the transmitter running -> all 40 transmitted in order, pointers wrap without corruption.
REQ-034 Timeout: tx_empty held 1 permanently, two bytes written -> tx_wr pulses separated by BUSY_TIMEOUT+2 cycles; FSM never hangs.
REQ-035 Reset mid-operation: rst=0 for one cycle while 3 bytes are queued and FSM is in WAIT_DONE -> all outputs at reset values immediately, no further tx_wr pulses.
